loop_sequencer: RTL and testbench
=================================

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 Reset rst, asynchronous, active-high; clock clk.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  async active-high reset.
REQ-004 start  in  1  jalfor decoded this cycle (single-cycle pulse from decode).
REQ-005 pc  in  32  current PC of the instruction in decode.
REQ-006 target  in  16  loop body start byte address (instruction[15:0]).
REQ-007 body_len  in  5  instructions per body pass (rs field).
REQ-008 trip_count  in  5  number of body passes (rt field).
REQ-009 stall  in  1  datapath frozen this cycle; sequencer holds.
REQ-010 abort  in  1  cancel active loop, resume at return address.
REQ-011 pc_sel  out  1  next PC taken from next_pc instead of pc+4.
REQ-012 next_pc  out  32  redirect address, 0 when pc_sel=0.
REQ-013 busy  out  1  loop active (state RUN).
REQ-014 iter  out  5  current 0-based pass index.
REQ-015 ret_addr  out  32  captured pc+4 of the jalfor, for $31 link write.
REQ-016 done  out  1  one-cycle pulse in the loop exit cycle.

Function
REQ-017 FSM states IDLE, RUN; outputs pc_sel, next_pc, done are combinational from state, registers and inputs; all state updates occur only on non-stalled rising edges.
REQ-018 Base address base = {pc[31:28], 12'b0, target[15:2], 2'b00}, captured at start.
REQ-019 IDLE, start=1, stall=0, body_len>0, trip_count>0: pc_sel=1, next_pc=base same cycle; capture base, ret_addr=pc+4, slot=body_len-1, iter=0, trips=trip_count; go RUN.
REQ-020 IDLE, start=1, stall=0, body_len=0 or trip_count=0: pc_sel=0, done=1 same cycle, ret_addr=pc+4 captured, stay IDLE.
REQ-021 RUN, slot>0: pc_sel=0, slot decrements.
REQ-022 RUN, slot=0, iter<trips-1: pc_sel=1, next_pc=base, iter increments, slot reloads body_len-1.
REQ-023 RUN, slot=0, iter=trips-1: pc_sel=1, next_pc=ret_addr, done=1, go IDLE, iter clears to 0.
REQ-024 start while RUN is ignored (no nesting); state unaffected.
REQ-025 stall=1: pc_sel=0, done=0, no register changes, start ignored (decode re-presents it).
REQ-026 Counter arithmetic 5-bit unsigned; trip_count=31, body_len=31 run full 961 body cycles without wrap.
REQ-027 busy=1 exactly while state is RUN.

Reset
REQ-028 rst asserted (any time, including mid-loop): state IDLE, slot=0, iter=0, trips=0, base=0, ret_addr=0; hence pc_sel=0, next_pc=0, busy=0, done=0.
REQ-029 First non-stalled edge after rst release behaves as IDLE.

Configuration
REQ-030 Macro LOOP_SEQ_ABORT_EN defined: RUN, abort=1, stall=0 -> pc_sel=1, next_pc=ret_addr, done=1, go IDLE; abort takes priority over REQ-021..023.
REQ-031 Macro undefined: abort port present but ignored; loop always runs to completion.

Structure
REQ-032 Shared package mips_pkg holds state enum (IDLE, RUN), WORD_W=32, LOOP_CNT_W=5.
REQ-033 One sub-module slot_counter: loadable 5-bit down-counter with enable and zero flag, used for slot.

Verification
REQ-034 pc=0x40, target=0x0100, body_len=3, trip_count=2 -> pc_sel pattern 1,0,0,1,0,0,1; next_pc 0x100,-,-,0x100,-,-,0x44; done only on 7th cycle; iter 0,0,0,1,1,1,1.
REQ-035 body_len=1, trip_count=3, target=0x0020, pc=0x10 -> pc_sel=1 every cycle for 4 cycles, next_pc 0x20,0x20,0x20,0x14, done on 4th.
REQ-036 trip_count=0 with start -> pc_sel=0, done=1 same cycle, busy stays 0, ret_addr=pc+4.
REQ-037 stall held 2 cycles mid-body in REQ-034 run -> sequence stretched by exactly 2 cycles, pc_sel/done 0 during stall, start pulse during RUN ignored.
REQ-038 rst pulsed during RUN at iter=1 -> all outputs 0 immediately (async), next start begins fresh with iter=0.
REQ-039 LOOP_SEQ_ABORT_EN defined, abort at iter=0 slot=1 -> pc_sel=1, next_pc=ret_addr, done=1, busy=0 next cycle; undefined -> abort has no effect.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and widths for the loop sequencer: FSM state enum, datapath widths,
// and the loop-base address helper.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int LOOP_CNT_W = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  // Loop body start: keep the 256 MB region of pc, word-align the 16-bit target.
  function automatic logic [WORD_W-1:0] loop_base(input logic [WORD_W-1:0] pc,
                                                  input logic [15:0]       target);
    return {pc[31:28], 12'h000, target & 16'hFFFC};
  endfunction

endpackage

// File: rtl/loop_sequencer_slot_counter.sv
// Loadable down-counter for the remaining instruction slots of the current body pass.
// Load has priority over decrement; the counter saturates at zero.
module slot_counter
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [LOOP_CNT_W-1:0] i_load_val,
  input  logic                  i_en,
  output logic                  o_zero
);

  localparam logic [LOOP_CNT_W-1:0] ONE = LOOP_CNT_W'(1);

  logic [LOOP_CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - ONE;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/loop_sequencer.sv
// jalfor hardware loop sequencer: redirects fetch to the loop body trip_count times,
// then returns to pc+4 of the jalfor. Optional abort support: define LOOP_SEQ_ABORT_EN.
module loop_sequencer
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_W-1:0]     pc,
  input  logic [15:0]           target,
  input  logic [LOOP_CNT_W-1:0] body_len,
  input  logic [LOOP_CNT_W-1:0] trip_count,
  input  logic                  stall,
  input  logic                  abort,
  output logic                  pc_sel,
  output logic [WORD_W-1:0]     next_pc,
  output logic                  busy,
  output logic [LOOP_CNT_W-1:0] iter,
  output logic [WORD_W-1:0]     ret_addr,
  output logic                  done,
  output logic [0:0]            dbg_state
);

  localparam logic [0:0]            S_IDLE = IDLE;
  localparam logic [0:0]            S_RUN  = RUN;
  localparam logic [LOOP_CNT_W-1:0] CNT_ONE = LOOP_CNT_W'(1);

  logic [0:0]            r_state;
  logic [LOOP_CNT_W-1:0] r_iter;
  logic [LOOP_CNT_W-1:0] r_trips;
  logic [LOOP_CNT_W-1:0] r_body_m1;
  logic [WORD_W-1:0]     r_base;
  logic [WORD_W-1:0]     r_ret;

  logic                  w_start_ok;
  logic                  w_start_loop;
  logic                  w_start_empty;
  logic                  w_run;
  logic                  w_abort;
  logic                  w_slot_zero;
  logic                  w_last_pass;
  logic                  w_wrap;
  logic                  w_exit;
  logic                  w_slot_dec;
  logic                  w_slot_load;
  logic [LOOP_CNT_W-1:0] w_slot_val;
  logic [WORD_W-1:0]     w_base;

  // Handshake: start is consumed only on a non-stalled edge while IDLE; any stalled
  // cycle freezes every register and forces pc_sel/done low so decode can re-present.
  assign w_start_ok    = (r_state == S_IDLE) && start && !stall;
  assign w_start_loop  = w_start_ok && (body_len != '0) && (trip_count != '0);
  assign w_start_empty = w_start_ok && !w_start_loop;
  assign w_run         = (r_state == S_RUN) && !stall;
  assign w_base        = loop_base(pc, target);

`ifdef LOOP_SEQ_ABORT_EN
  assign w_abort = w_run & abort;
`else
  assign w_abort = 1'b0 & abort;
`endif

  assign w_last_pass = (r_iter == (r_trips - CNT_ONE));
  assign w_wrap      = w_run && !w_abort && w_slot_zero && !w_last_pass;
  assign w_exit      = w_run && !w_abort && w_slot_zero && w_last_pass;
  assign w_slot_dec  = w_run && !w_abort && !w_slot_zero;
  assign w_slot_load = w_start_loop || w_wrap || w_abort;

  always_comb begin
    w_slot_val = r_body_m1;
    if (w_start_loop) begin
      w_slot_val = body_len - CNT_ONE;
    end else if (w_abort) begin
      w_slot_val = '0;
    end
  end

  slot_counter u_slot (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_slot_load),
    .i_load_val (w_slot_val),
    .i_en       (w_slot_dec),
    .o_zero     (w_slot_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_iter    <= '0;
      r_trips   <= '0;
      r_body_m1 <= '0;
      r_base    <= '0;
      r_ret     <= '0;
    end else begin
      if (w_start_ok) begin
        r_ret <= pc + 32'd4;
      end
      if (w_start_loop) begin
        r_state   <= S_RUN;
        r_base    <= w_base;
        r_iter    <= '0;
        r_trips   <= trip_count;
        r_body_m1 <= body_len - CNT_ONE;
      end else if (w_wrap) begin
        r_iter <= r_iter + CNT_ONE;
      end else if (w_exit || w_abort) begin
        r_state <= S_IDLE;
        r_iter  <= '0;
      end
    end
  end

  always_comb begin
    next_pc = '0;
    if (w_start_loop) begin
      next_pc = w_base;
    end else if (w_wrap) begin
      next_pc = r_base;
    end else if (w_exit || w_abort) begin
      next_pc = r_ret;
    end
  end

  assign pc_sel    = w_start_loop || w_wrap || w_exit || w_abort;
  assign done      = w_start_empty || w_exit || w_abort;
  assign busy      = (r_state == S_RUN);
  // In a wrap cycle the redirect already belongs to the next pass, so report that pass.
  assign iter      = w_wrap ? (r_iter + CNT_ONE) : r_iter;
  assign ret_addr  = r_ret;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_loop_sequencer.sv
// Self-checking bench for loop_sequencer: cycle schedule model, directed scenarios, random loops.
`timescale 1ns/1ps
module tb_loop_sequencer;

  typedef struct packed {
    logic        pc_sel;
    logic [31:0] next_pc;
    logic        done;
    logic [4:0]  iter;
    logic        busy;
    logic [31:0] ret_addr;
  } exp_t;

  typedef struct packed {
    logic        pc_sel;
    logic [31:0] next_pc;
    logic        done;
    logic [4:0]  iter;
  } sched_t;

`ifdef LOOP_SEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic [15:0] target;
  logic [4:0]  body_len;
  logic [4:0]  trip_count;
  logic        stall;
  logic        abort;
  logic        pc_sel;
  logic [31:0] next_pc;
  logic        busy;
  logic [4:0]  iter;
  logic [31:0] ret_addr;
  logic        done;
  logic [0:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  exp_t        exp_q[$];
  sched_t      sched_q[$];
  logic [31:0] m_ret  = '0;
  logic [4:0]  m_iter = '0;

  int          log_idx = 0;
  logic        log_sel  [0:15];
  logic [31:0] log_npc  [0:15];
  logic        log_done [0:15];
  logic [4:0]  log_iter [0:15];
  logic        log_busy [0:15];

  always #5 clk = ~clk;

  loop_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pc         (pc),
    .target     (target),
    .body_len   (body_len),
    .trip_count (trip_count),
    .stall      (stall),
    .abort      (abort),
    .pc_sel     (pc_sel),
    .next_pc    (next_pc),
    .busy       (busy),
    .iter       (iter),
    .ret_addr   (ret_addr),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-loop schedule: one entry per non-stalled cycle, from the start cycle to the exit cycle.
  function automatic void build_sched(input logic [31:0] p, input logic [15:0] tg,
                                      input logic [4:0] bl, input logic [4:0] tc);
    logic [31:0] base;
    base = {p[31:28], 12'h000, tg[15:2], 2'b00};
    sched_q.delete();
    for (int k = 0; k < int'(tc); k++) begin
      for (int s = 0; s < int'(bl); s++) begin
        sched_q.push_back('{pc_sel: (s == 0), next_pc: ((s == 0) ? base : 32'h0),
                            done: 1'b0, iter: 5'(k)});
      end
    end
    sched_q.push_back('{pc_sel: 1'b1, next_pc: p + 32'd4, done: 1'b1, iter: tc - 5'd1});
  endfunction

  task automatic drive(input logic st, input logic [31:0] p, input logic [15:0] tg,
                       input logic [4:0] bl, input logic [4:0] tc, input logic sl, input logic ab);
    exp_t   e;
    sched_t s;
    @(posedge clk);
    #1;
    start = st; pc = p; target = tg; body_len = bl; trip_count = tc; stall = sl; abort = ab;
    e.busy     = (sched_q.size() != 0);
    e.ret_addr = m_ret;
    e.pc_sel   = 1'b0;
    e.next_pc  = '0;
    e.done     = 1'b0;
    e.iter     = m_iter;
    if (!sl) begin
      if (sched_q.size() == 0) begin
        if (st) begin
          m_ret = p + 32'd4;
          if (bl == 5'd0 || tc == 5'd0) begin
            e.done = 1'b1;
          end else begin
            build_sched(p, tg, bl, tc);
            s = sched_q.pop_front();
            e.pc_sel = s.pc_sel; e.next_pc = s.next_pc; e.done = s.done; e.iter = s.iter;
            m_iter = s.iter;
          end
        end
      end else if (ABORT_EN && ab) begin
        e.pc_sel = 1'b1; e.next_pc = m_ret; e.done = 1'b1;
        sched_q.delete();
        m_iter = '0;
      end else begin
        s = sched_q.pop_front();
        e.pc_sel = s.pc_sel; e.next_pc = s.next_pc; e.done = s.done; e.iter = s.iter;
        m_iter = (sched_q.size() == 0) ? 5'd0 : s.iter;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_pc_sel"},   32'(pc_sel),   32'h0);
    chk({tag, "_next_pc"},  next_pc,       32'h0);
    chk({tag, "_busy"},     32'(busy),     32'h0);
    chk({tag, "_done"},     32'(done),     32'h0);
    chk({tag, "_iter"},     32'(iter),     32'h0);
    chk({tag, "_ret_addr"}, ret_addr,      32'h0);
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #3;
    start = 1'b0; stall = 1'b0; abort = 1'b0;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    sched_q.delete();
    m_iter = '0;
    m_ret  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] sel_pat(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[n-1-i] = log_sel[i];
    return v;
  endfunction

  function automatic logic [31:0] done_pat(input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[n-1-i] = log_done[i];
    return v;
  endfunction

  // Compare process: every driven cycle is checked against the model at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_sel",    32'(pc_sel),    32'(e.pc_sel));
      chk("next_pc",   next_pc,        e.next_pc);
      chk("done",      32'(done),      32'(e.done));
      chk("iter",      32'(iter),      32'(e.iter));
      chk("busy",      32'(busy),      32'(e.busy));
      chk("ret_addr",  ret_addr,       e.ret_addr);
      chk("dbg_state", 32'(dbg_state), 32'(e.busy));
      if (log_idx < 16) begin
        log_sel[log_idx]  = pc_sel;
        log_npc[log_idx]  = next_pc;
        log_done[log_idx] = done;
        log_iter[log_idx] = iter;
        log_busy[log_idx] = busy;
      end
      log_idx++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rp;
    logic [15:0] rtg;
    logic [4:0]  rbl;
    logic [4:0]  rtc;
    int          guard;
    int          cnt;

    rst = 1'b1; start = 1'b0; pc = '0; target = '0; body_len = '0; trip_count = '0;
    stall = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Basic loop: 3-instruction body, 2 passes.
    settle(); log_idx = 0;
    drive(1'b1, 32'h40, 16'h0100, 5'd3, 5'd2, 1'b0, 1'b0);
    idle(6);
    settle();
    chk("loop32_sel_pat",  sel_pat(7),  32'b1001001);
    chk("loop32_done_pat", done_pat(7), 32'b0000001);
    chk("loop32_npc0",     log_npc[0],  32'h100);
    chk("loop32_npc3",     log_npc[3],  32'h100);
    chk("loop32_npc6",     log_npc[6],  32'h44);
    chk("loop32_iter2",    32'(log_iter[2]), 32'd0);
    chk("loop32_iter3",    32'(log_iter[3]), 32'd1);
    chk("loop32_iter6",    32'(log_iter[6]), 32'd1);
    chk("loop32_busy0",    32'(log_busy[0]), 32'd0);
    chk("loop32_busy1",    32'(log_busy[1]), 32'd1);

    // Single-instruction body: redirect every cycle.
    log_idx = 0;
    drive(1'b1, 32'h10, 16'h0020, 5'd1, 5'd3, 1'b0, 1'b0);
    idle(3);
    settle();
    chk("loop13_sel_pat",  sel_pat(4),  32'b1111);
    chk("loop13_done_pat", done_pat(4), 32'b0001);
    chk("loop13_npc2",     log_npc[2],  32'h20);
    chk("loop13_npc3",     log_npc[3],  32'h14);

    // Zero trip count: immediate done, no loop.
    log_idx = 0;
    drive(1'b1, 32'h200, 16'h0100, 5'd4, 5'd0, 1'b0, 1'b0);
    idle(1);
    settle();
    chk("zero_trip_done",  32'(log_done[0]), 32'd1);
    chk("zero_trip_sel",   32'(log_sel[0]),  32'd0);
    chk("zero_trip_busy",  32'(log_busy[1]), 32'd0);
    chk("zero_trip_ret",   ret_addr,         32'h204);

    // Stall two cycles mid-body, with start pulses during the run.
    log_idx = 0;
    drive(1'b1, 32'h40, 16'h0100, 5'd3, 5'd2, 1'b0, 1'b0);
    drive(1'b0, 32'h0,  16'h0,    5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 32'h0,  16'h0,    5'd0, 5'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h80, 16'h0400, 5'd2, 5'd2, 1'b1, 1'b0);
    drive(1'b0, 32'h0,  16'h0,    5'd0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 32'h80, 16'h0400, 5'd2, 5'd2, 1'b0, 1'b0);
    drive(1'b1, 32'h90, 16'h0500, 5'd1, 5'd1, 1'b0, 1'b0);
    idle(2);
    settle();
    chk("stall_sel_pat",  sel_pat(9),  32'b100001001);
    chk("stall_done_pat", done_pat(9), 32'b000000001);
    chk("stall_npc8",     log_npc[8],  32'h44);

    // Asynchronous reset in the second pass, then a fresh loop.
    drive(1'b1, 32'h40, 16'h0100, 5'd3, 5'd2, 1'b0, 1'b0);
    idle(4);
    reset_mid_cycle();
    log_idx = 0;
    drive(1'b1, 32'h10, 16'h0020, 5'd1, 5'd3, 1'b0, 1'b0);
    idle(3);
    settle();
    chk("after_rst_iter0", 32'(log_iter[0]), 32'd0);
    chk("after_rst_npc3",  log_npc[3],       32'h14);

    // Abort at pass 0 with one slot left.
    log_idx = 0;
    drive(1'b1, 32'h40, 16'h0100, 5'd3, 5'd2, 1'b0, 1'b0);
    idle(1);
    drive(1'b0, 32'h0, 16'h0, 5'd0, 5'd0, 1'b0, 1'b1);
    idle(5);
    settle();
`ifdef LOOP_SEQ_ABORT_EN
    chk("abort_sel",  32'(log_sel[2]),  32'd1);
    chk("abort_npc",  log_npc[2],       32'h44);
    chk("abort_done", 32'(log_done[2]), 32'd1);
    chk("abort_busy", 32'(log_busy[3]), 32'd0);
`else
    chk("abort_sel",  32'(log_sel[2]),  32'd0);
    chk("abort_done", 32'(log_done[2]), 32'd0);
    chk("abort_busy", 32'(log_busy[3]), 32'd1);
`endif

    // Longest loop: 31 x 31 body cycles plus the exit cycle.
    log_idx = 0;
    drive(1'b1, 32'hA000_0000, 16'hFFFF, 5'd31, 5'd31, 1'b0, 1'b0);
    cnt = 1;
    while (sched_q.size() != 0 && cnt < 1000) begin
      idle(1);
      cnt++;
    end
    chk("full_len", 32'(cnt), 32'd962);
    settle();
    chk("full_base", log_npc[0], 32'hA000_FFFC);

    // Random loops with stalls, stray starts and aborts.
    for (int n = 0; n < 40; n++) begin
      rp  = $urandom;
      rtg = 16'($urandom);
      rbl = 5'($urandom_range(0, 5));
      rtc = 5'($urandom_range(0, 4));
      drive(1'b1, rp, rtg, rbl, rtc, 1'b0, 1'b0);
      guard = 0;
      while (sched_q.size() != 0 && guard < 300) begin
        drive($urandom_range(0, 3) == 0, $urandom, 16'($urandom), 5'($urandom), 5'($urandom),
              $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
        guard++;
      end
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        drive($urandom_range(0, 1) == 1, $urandom, 16'($urandom), 5'd2, 5'd2, 1'b1, 1'b0);
      end
    end
    idle(2);
    settle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
